// File: rtl/ws2812_frame_sched.sv
// ws2812_frame_sched
// Frame scheduler for a WS2812 LED chain. Holds NUM_LEDS pixels as {g,r,b},
// and on a trigger (manual refresh_req, the auto-refresh tick, or a pending
// trigger caught mid-frame) streams them in index order to a downstream bit
// serializer over a valid/ready handshake. After the last pixel it holds the
// line idle for LATCH_CYCLES clocks so the chain latches, then pulses
// frame_done.
//
// Ports
//   clk          system clock, rising edge
//   reset        synchronous active-high reset
//   wr_en        pixel write strobe (accepted in any state)
//   wr_addr      pixel index; indices >= NUM_LEDS are ignored
//   wr_r/g/b     pixel colour
//   refresh_req  manual frame trigger
//   px_valid     pixel word offered to the serializer
//   px_grb       pixel word in wire order {g,r,b}
//   px_ready     serializer accepts the offered word
//   busy         frame in progress (LOAD, SEND or LATCH)
//   frame_done   one-cycle pulse when the latch gap completes
module ws2812_frame_sched #(
  parameter int NUM_LEDS     = 8,
  parameter int AW           = 3,
  parameter int LATCH_CYCLES = 13500,
  parameter int REFRESH_DIV  = 450000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_r,
  input  logic [7:0]    wr_g,
  input  logic [7:0]    wr_b,
  input  logic          refresh_req,
  output logic          px_valid,
  output logic [23:0]   px_grb,
  input  logic          px_ready,
  output logic          busy,
  output logic          frame_done
);

  localparam int LW = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [LW-1:0] LATCH_LAST   = LW'(LATCH_CYCLES - 1);
  localparam logic [RW-1:0] REFRESH_LAST = RW'((REFRESH_DIV > 0) ? REFRESH_DIV - 1 : 0);
  localparam logic [AW-1:0] IDX_LAST     = AW'(NUM_LEDS - 1);
  localparam logic [AW:0]   NUM_LEDS_W   = (AW + 1)'(NUM_LEDS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SEND  = 2'd2,
    LATCH = 2'd3
  } state_t;

  state_t          state;
  logic [23:0]     pix [NUM_LEDS];
  logic [AW-1:0]   idx;
  logic            pending;
  logic [LW-1:0]   lcnt;
  logic [RW-1:0]   rcnt;

  logic            tick;
  logic            trig;
  logic            wr_hit;
  logic [23:0]     wr_word;

  assign wr_word = {wr_g, wr_r, wr_b};
  assign wr_hit  = wr_en && ({1'b0, wr_addr} < NUM_LEDS_W);
  // A tick and a manual request in the same cycle collapse into one trigger.
  assign tick    = (REFRESH_DIV != 0) && (rcnt == REFRESH_LAST);
  assign trig    = refresh_req || tick;

  // Pixel store: writes land in any FSM state.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_LEDS; i++) pix[i] <= '0;
    end else if (wr_hit) begin
      pix[wr_addr] <= wr_word;
    end
  end

  // Free-running auto-refresh divider, independent of the frame FSM.
  always_ff @(posedge clk) begin
    if (reset || tick) rcnt <= '0;
    else               rcnt <= rcnt + RW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      pending    <= 1'b0;
      lcnt       <= '0;
      px_valid   <= 1'b0;
      px_grb     <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      // Triggers during a frame fold into a single pending flag; the clears
      // below on frame start take priority over this set.
      if (state != IDLE && trig) pending <= 1'b1;
      case (state)
        IDLE: begin
          if (trig || pending) begin
            state   <= LOAD;
            idx     <= '0;
            pending <= 1'b0;
            busy    <= 1'b1;
          end
        end
        LOAD: begin
          // Write-first: a write to the pixel being loaded is forwarded.
          px_grb   <= (wr_hit && wr_addr == idx) ? wr_word : pix[idx];
          px_valid <= 1'b1;
          state    <= SEND;
        end
        SEND: begin
          if (px_ready) begin
            px_valid <= 1'b0;
            if (idx == IDX_LAST) begin
              lcnt  <= '0;
              state <= LATCH;
            end else begin
              idx   <= idx + AW'(1);
              state <= LOAD;
            end
          end
        end
        LATCH: begin
          if (lcnt == LATCH_LAST) begin
            frame_done <= 1'b1;
            if (pending) begin
              state   <= LOAD;
              idx     <= '0;
              pending <= 1'b0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            lcnt <= lcnt + LW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
